// File: rtl/ttl_74259_sync.sv
// ttl_74259_sync -- synchronous model of an SN74LS259 8-bit addressable latch.
// One data bit D is steered by address S into one of eight storage bits. Updates
// happen only at a strobe instant, which is either a detected falling edge of Cen
// (EDGE_CEN=1) or any cycle with Cen high (EDGE_CEN=0).
//
// Ports:
//   clk        system clock, rising edge
//   VIDEO_RST  asynchronous active-high reset
//   Cen        enable strobe
//   Gn         latch enable, active low
//   CLRn       clear, active low
//   S[2:0]     bit address
//   D          data bit
//   Q[7:0]     latched outputs
//   Qn[7:0]    complement of Q
//   upd        high for one clk after every strobe instant (including memory mode)
module ttl_74259_sync #(
  parameter logic [7:0] RESET_VALUE = 8'h00,
  parameter bit         EDGE_CEN    = 1'b1
) (
  input  logic       clk,
  input  logic       VIDEO_RST,
  input  logic       Cen,
  input  logic       Gn,
  input  logic       CLRn,
  input  logic [2:0] S,
  input  logic       D,
  output logic [7:0] Q,
  output logic [7:0] Qn,
  output logic       upd
);

  logic       last_cen;
  logic       strobe;
  logic [7:0] q_next;

  // last_cen resets high so the first Cen=0 after reset is seen as a falling edge.
  assign strobe = EDGE_CEN ? (~Cen & last_cen) : Cen;

  // Per-bit next value, collapsing the four {Gn,CLRn} modes:
  //   Gn=0: addressed bit takes D; others hold (CLRn=1) or clear (CLRn=0).
  //   Gn=1: all bits hold (CLRn=1) or clear (CLRn=0).
  for (genvar i = 0; i < 8; i++) begin : g_bit
    logic hit;
    assign hit       = (S == 3'(i));
    assign q_next[i] = Gn ? (CLRn & Q[i]) : (hit ? D : (CLRn & Q[i]));
  end

  always_ff @(posedge clk or posedge VIDEO_RST) begin
    if (VIDEO_RST) begin
      Q        <= RESET_VALUE;
      upd      <= 1'b0;
      last_cen <= 1'b1;
    end else begin
      last_cen <= Cen;
      upd      <= strobe;
      if (strobe) Q <= q_next;
    end
  end

  assign Qn = ~Q;

endmodule

// File: tb/tb_ttl_74259_sync.sv
// Scoreboard bench for ttl_74259_sync. Two instances: u_edge (EDGE_CEN=1, reset
// value 00) and u_lvl (EDGE_CEN=0, reset value 5A) share Gn/CLRn/S/D/VIDEO_RST but
// have separate Cen inputs. The driver computes the expected byte with a plain
// arithmetic model and queues it at every strobe; per-instance monitors pop on upd
// and otherwise require Q to hold its last value.
module tb_ttl_74259_sync;

  localparam logic [7:0] RV_E = 8'h00;
  localparam logic [7:0] RV_L = 8'h5A;

  logic       clk = 1'b0;
  logic       VIDEO_RST = 1'b1;
  logic       cen_e = 1'b1, cen_l = 1'b0;
  logic       Gn = 1'b1, CLRn = 1'b1, D = 1'b0;
  logic [2:0] S = 3'd0;
  logic [7:0] q_e, qn_e, q_l, qn_l;
  logic       upd_e, upd_l;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_e[$];
  logic [7:0] exp_l[$];
  logic [7:0] m_e = RV_E, m_l = RV_L;   // model contents
  logic [7:0] cur_e = RV_E, cur_l = RV_L; // last value confirmed by the monitors
  bit         prev_cen = 1'b1;

  always #5 clk = ~clk;

  ttl_74259_sync #(.RESET_VALUE(RV_E), .EDGE_CEN(1'b1)) u_edge (
    .clk(clk), .VIDEO_RST(VIDEO_RST), .Cen(cen_e), .Gn(Gn), .CLRn(CLRn),
    .S(S), .D(D), .Q(q_e), .Qn(qn_e), .upd(upd_e));

  ttl_74259_sync #(.RESET_VALUE(RV_L), .EDGE_CEN(1'b0)) u_lvl (
    .clk(clk), .VIDEO_RST(VIDEO_RST), .Cen(cen_l), .Gn(Gn), .CLRn(CLRn),
    .S(S), .D(D), .Q(q_l), .Qn(qn_l), .upd(upd_l));

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference behaviour of one strobe, straight from the mode table.
  function automatic logic [7:0] apply(logic [7:0] q, bit gn, bit clrn, logic [2:0] s, bit d);
    logic [7:0] bitmask;
    bitmask = 8'd1 << s;
    case ({gn, clrn})
      2'b01:   return d ? (q | bitmask) : (q & ~bitmask); // addressable latch
      2'b11:   return q;                                  // memory
      2'b00:   return d ? bitmask : 8'h00;                // 1-of-8 demux
      default: return 8'h00;                              // clear
    endcase
  endfunction

  // Drive one cycle of inputs at the falling clk edge and update the model.
  task automatic cyc(bit ce, bit cl, bit gn, bit clrn, logic [2:0] s, bit d);
    @(negedge clk);
    cen_e = ce; cen_l = cl; Gn = gn; CLRn = clrn; S = s; D = d;
    if (!VIDEO_RST) begin
      if (!ce && prev_cen) begin
        m_e = apply(m_e, gn, clrn, s, d);
        exp_e.push_back(m_e);
      end
      prev_cen = ce;
      if (cl) begin
        m_l = apply(m_l, gn, clrn, s, d);
        exp_l.push_back(m_l);
      end
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  // Monitors: sample 2 time units after the rising edge.
  always @(posedge clk) begin
    #2;
    if (VIDEO_RST) begin
      chk("edge_rst_q", q_e, RV_E);
      chk("edge_rst_upd", {7'd0, upd_e}, 8'd0);
      cur_e = RV_E;
    end else if (upd_e) begin
      if (exp_e.size() == 0) chk("edge_spurious_upd", q_e, cur_e ^ 8'hFF);
      else begin
        cur_e = exp_e.pop_front();
        chk("edge_q_upd", q_e, cur_e);
      end
    end else chk("edge_q_hold", q_e, cur_e);
    chk("edge_qn", qn_e, ~q_e);
  end

  always @(posedge clk) begin
    #2;
    if (VIDEO_RST) begin
      chk("lvl_rst_q", q_l, RV_L);
      cur_l = RV_L;
    end else if (upd_l) begin
      if (exp_l.size() == 0) chk("lvl_spurious_upd", q_l, cur_l ^ 8'hFF);
      else begin
        cur_l = exp_l.pop_front();
        chk("lvl_q_upd", q_l, cur_l);
      end
    end else chk("lvl_q_hold", q_l, cur_l);
    chk("lvl_qn", qn_l, ~q_l);
  end

  initial begin
    // Reset held for 3 clk with Cen toggling.
    for (int i = 0; i < 3; i++) begin
      cyc(i[0], 1'b0, 1'b0, 1'b1, 3'd5, 1'b1);
      settle();
      chk("reset_q", q_e, 8'h00);
      chk("reset_qn", qn_e, 8'hFF);
    end
    @(negedge clk);
    cen_e = 1'b1;
    VIDEO_RST = 1'b0;
    prev_cen = 1'b1;
    m_e = RV_E; m_l = RV_L;

    // First falling edge after reset.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1);
    settle();
    chk("first_q", q_e, 8'h20);
    chk("first_upd", {7'd0, upd_e}, 8'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1); // Cen held low: no new strobe
    settle();
    chk("first_upd_drop", {7'd0, upd_e}, 8'd0);
    chk("held_low_q", q_e, 8'h20);

    // Clear, then addressable latch walk.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    settle();
    chk("clear_q", q_e, 8'h00);
    for (int s = 0; s < 8; s++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'(s), 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'(s), 1'b1);
      settle();
      chk("walk_q", q_e, 8'((1 << (s + 1)) - 1));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    settle();
    chk("walk_clr3", q_e, 8'hF7);

    // Memory mode still pulses upd; no edges for 20 clk means no change.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1);
    settle();
    chk("mem_q", q_e, 8'hF7);
    chk("mem_upd", {7'd0, upd_e}, 8'd1);
    for (int i = 0; i < 20; i++)
      cyc(i >= 10, 1'b0, 1'b0, $urandom_range(1), 3'($urandom_range(7)), $urandom_range(1));
    settle();
    chk("hold20_q", q_e, 8'hF7);

    // Demux and clear, starting from FF.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1); // Cen already high: falling edge
    settle();
    chk("ff_q", q_e, 8'hFF);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1);
    settle();
    chk("demux_q", q_e, 8'h40);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 3'd6, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd6, 1'b1);
    settle();
    chk("clr_q", q_e, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
    settle();
    chk("demux_d0_q", q_e, 8'h00);

    // Build AA, then reset on the same cycle as a Cen falling edge.
    for (int s = 1; s < 8; s += 2) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'(s), 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'(s), 1'b1);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
    settle();
    chk("aa_q", q_e, 8'hAA);
    @(negedge clk);
    cen_e = 1'b0; Gn = 1'b0; CLRn = 1'b1; S = 3'd0; D = 1'b1;
    #1 VIDEO_RST = 1'b1;
    #1 chk("async_rst_q", q_e, RV_E);
    exp_e.delete(); exp_l.delete();
    m_e = RV_E; m_l = RV_L; prev_cen = 1'b1;
    @(negedge clk);
    cen_e = 1'b1;
    @(negedge clk);
    VIDEO_RST = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1);
    settle();
    chk("post_rst_q", q_e, RV_E);

    // Level-enable instance: clear, then 01,03,07, then hold with Cen=0.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    settle();
    chk("lvl_clear", q_l, 8'h00);
    for (int s = 0; s < 3; s++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'(s), 1'b1);
      settle();
      chk("lvl_step", q_l, 8'((1 << (s + 1)) - 1));
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1);
    settle();
    chk("lvl_hold", q_l, 8'h07);

    // Randomized traffic on both instances.
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(1), $urandom_range(3) == 0, $urandom_range(1),
          $urandom_range(3) != 0, 3'($urandom_range(7)), $urandom_range(1));
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
    repeat (3) @(posedge clk);
    #4;
    chk("edge_queue_drained", 8'(exp_e.size()), 8'd0);
    chk("lvl_queue_drained", 8'(exp_l.size()), 8'd0);
    chk("final_edge_q", q_e, m_e);
    chk("final_lvl_q", q_l, m_l);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ttl_74259_sync.md
Name: ttl_74259_sync

Overview:
- Synchronous model of an SN74LS259 8-bit addressable latch: one data bit D is steered by a 3-bit address S into one of eight storage bits.
- It is the demultiplexing counterpart of the quad 2-input mux-with-storage. A single serial/control bit fans out to eight registered outputs.
- It serves as a board-level control latch: scroll enables, flip, and sound/video strobes.
- All state is clocked by the single system clock. Updates are qualified by detecting a falling edge of the Cen enable, the same strobe convention as the other synchronous TTL models.

Parameters:
- RESET_VALUE, 8'h00, contents of Q on reset.
- EDGE_CEN, 1, 1 = update only on a detected Cen falling edge; 0 = update on every clk cycle where Cen=1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- VIDEO_RST  input  1  asynchronous active-high reset.
- Cen  input  1  enable strobe; its falling edge defines an update instant when EDGE_CEN=1.
- Gn  input  1  latch enable, active low.
- CLRn  input  1  clear, active low.
- S  input  3  bit address, 0..7.
- D  input  1  data bit.
- Q  output  8  latched outputs, Q[S] is addressed bit.
- Qn  output  8  bitwise complement of Q.
- upd  output  1  registered flag, high for one clk after any update instant (debug/verification).

Behaviour:
- Reset: VIDEO_RST=1 asynchronously forces Q=RESET_VALUE, upd=0, last_cen=1. Reset has priority over everything. Reset asserted mid-strobe discards that update.
- Strobe:
  - EDGE_CEN=1: strobe = (Cen==0) && (last_cen==1). last_cen <= Cen every clk.
  - EDGE_CEN=0: strobe = Cen.
- Outside strobe cycles Q holds. Input changes between strobes have no effect.
- At a strobe, Q is updated on that same clk edge; new values are visible the following cycle (latency 1 clk from the strobe sample). Modes are selected by {Gn, CLRn} sampled on the strobe cycle:
  - Gn=0, CLRn=1, addressable latch: Q[S] <= D; other seven bits hold.
  - Gn=1, CLRn=1, memory: all bits hold.
  - Gn=0, CLRn=0, 1-of-8 demux: Q[S] <= D; all other bits <= 0.
  - Gn=1, CLRn=0, clear: Q <= 8'h00.
- upd <= strobe every clk, even in memory mode. upd is reset to 0.
- Qn = ~Q combinationally from the register; no extra delay.
- Cen held low: only one strobe; a new falling edge is required. Cen glitch high-for-one-clk then low produces a new strobe.
- A first Cen=0 after reset counts as a falling edge, because last_cen resets to 1.
- Address wrap: S is a full 3-bit address with no out-of-range case. Any X/Z on S at a strobe in latch/demux mode is a verification error; the RTL does not need to handle it.
- Consecutive strobes to the same address: the last write wins. No read-modify-write hazards beyond the single bit.

Test Plan:
- Reset, then EDGE_CEN=1: assert VIDEO_RST for 3 clk with Cen toggling. Q must be 8'h00 and Qn 8'hFF throughout. After release, the first Cen 1->0 with Gn=0, CLRn=1, S=5, D=1 gives Q=8'h20 one clk later, and upd pulses for exactly 1 clk.
- Addressable latch walk: write D=1 to S=0..7 on successive Cen falling edges. Q must progress 01,03,07,…,FF. Then write D=0 to S=3 and Q must equal F7.
- Memory and hold: from Q=F7, strobe with Gn=1, CLRn=1, D=1, S=3. Q stays F7 and upd still pulses. Toggling S/D with Cen held low or high (no falling edge) for 20 clk leaves Q unchanged.
- Demux and clear: from Q=FF, strobe with Gn=0, CLRn=0, S=6, D=1, giving Q=40. Then strobe Gn=1, CLRn=0, giving Q=00. Then strobe Gn=0, CLRn=0, S=2, D=0, giving Q=00.
- Async reset mid-operation: with Q=AA, assert VIDEO_RST between clk edges on the same cycle as a Cen falling edge. Q must go to RESET_VALUE immediately and the pending write must not appear after release.
- EDGE_CEN=0 variant: hold Cen=1 with Gn=0, CLRn=1, and step S=0,1,2 with D=1 per clk. Q must go 01,03,07 on consecutive cycles. With Cen=0, Q holds.
